// File: rtl/page_table_walker_if.sv
// Memory read port used by the page-table walker to fetch PTEs.
// One outstanding request; the address stays stable until ready.
interface page_table_walker_if;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ready_i;
  logic [31:0] mem_data_i;

  modport master (
    output mem_req_o,
    output mem_addr_o,
    input  mem_ready_i,
    input  mem_data_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_addr_o,
    output mem_ready_i,
    output mem_data_i
  );
endinterface

// File: rtl/page_table_walker.sv
// TLB miss handler: fetches one PTE per miss, then refills the TLB
// or raises a page fault (bus error on memory timeout).
module page_table_walker #(
  parameter int OFFSET    = 12,
  parameter int PTE_SHIFT = 2,
  parameter int TIMEOUT   = 255
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                tlb_miss_i,
  input  logic [31:0]         virtual_address_i,
  input  logic                privilege_i,
  input  logic [31:0]         ptbr_i,
  page_table_walker_if.master mem,
  output logic [31-OFFSET:0]  w_virtual_page_o,
  output logic [31-OFFSET:0]  w_phys_page_o,
  output logic                write_enable_o,
  output logic                stall_o,
  output logic                page_fault_o,
  output logic                bus_error_o,
  output logic [31:0]         fault_vaddr_o,
  input  logic                fault_ack_i
);

  localparam int VW = 32 - OFFSET;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    FILL,
    SETTLE,
    FAULT
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [31:0]     vaddr_q;
  logic [VW-1:0]   vpn_q;
  logic [31:0]     addr_q;
  logic            req_q;
  logic            stall_q;
  logic            we_q;
  logic            pf_q;
  logic            be_q;
  logic [31:0]     fva_q;
  logic [VW-1:0]   wvp_q;
  logic [VW-1:0]   wpp_q;

  logic            start;
  logic [31:0]     vpn_ext;
  logic            unused_pte_bits;

  assign start   = tlb_miss_i & ~privilege_i;
  assign vpn_ext = {{OFFSET{1'b0}}, virtual_address_i[31:OFFSET]};
  assign unused_pte_bits = ^mem.mem_data_i[OFFSET-1:1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vaddr_q <= '0;
      vpn_q   <= '0;
      addr_q  <= '0;
      req_q   <= 1'b0;
      stall_q <= 1'b0;
      we_q    <= 1'b0;
      pf_q    <= 1'b0;
      be_q    <= 1'b0;
      fva_q   <= '0;
      wvp_q   <= '0;
      wpp_q   <= '0;
    end else begin
      we_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            vaddr_q <= virtual_address_i;
            vpn_q   <= virtual_address_i[31:OFFSET];
            addr_q  <= ptbr_i + (vpn_ext << PTE_SHIFT);
            cnt_q   <= '0;
            req_q   <= 1'b1;
            stall_q <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          state_q <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          // ready takes priority over a coincident timeout
          if (mem.mem_ready_i) begin
            req_q <= 1'b0;
            if (mem.mem_data_i[0]) begin
              wvp_q   <= vpn_q;
              wpp_q   <= mem.mem_data_i[31:OFFSET];
              we_q    <= 1'b1;
              state_q <= FILL;
            end else begin
              pf_q    <= 1'b1;
              be_q    <= 1'b0;
              fva_q   <= vaddr_q;
              stall_q <= 1'b0;
              state_q <= FAULT;
            end
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            req_q   <= 1'b0;
            pf_q    <= 1'b1;
            be_q    <= 1'b1;
            fva_q   <= vaddr_q;
            stall_q <= 1'b0;
            state_q <= FAULT;
          end
        end
        FILL: begin
          state_q <= SETTLE;
        end
        SETTLE: begin
          // refilled entry is visible to the TLB only from now on
          stall_q <= 1'b0;
          state_q <= IDLE;
        end
        FAULT: begin
          if (fault_ack_i) begin
            pf_q    <= 1'b0;
            be_q    <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Hold the missing instruction in the very cycle the miss is seen
  assign stall_o = stall_q
                 | ((state_q == IDLE) & start & ~reset);

  assign mem.mem_req_o  = req_q;
  assign mem.mem_addr_o = addr_q;
  assign write_enable_o   = we_q;
  assign page_fault_o     = pf_q;
  assign bus_error_o      = be_q;
  assign fault_vaddr_o    = fva_q;
  assign w_virtual_page_o = wvp_q;
  assign w_phys_page_o    = wpp_q;

endmodule

// File: tb/tb_page_table_walker.sv
// Scoreboard bench for page_table_walker: directed walks push
// expected refills/faults; a negedge monitor pops and compares.
module tb_page_table_walker;

  logic        clock = 1'b0;
  logic        reset;
  logic        miss;
  logic [31:0] va;
  logic        priv;
  logic [31:0] ptbr;
  logic        ack;
  logic [19:0] wvp;
  logic [19:0] wpp;
  logic        we;
  logic        stall;
  logic        pf;
  logic        be;
  logic [31:0] fva;

  page_table_walker_if bus();

  page_table_walker dut (
    .clock             (clock),
    .reset             (reset),
    .tlb_miss_i        (miss),
    .virtual_address_i (va),
    .privilege_i       (priv),
    .ptbr_i            (ptbr),
    .mem               (bus),
    .w_virtual_page_o  (wvp),
    .w_phys_page_o     (wpp),
    .write_enable_o    (we),
    .stall_o           (stall),
    .page_fault_o      (pf),
    .bus_error_o       (be),
    .fault_vaddr_o     (fva),
    .fault_ack_i       (ack)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    bit          fault;
    logic [19:0] vpn;
    logic [19:0] ppn;
    bit          berr;
    logic [31:0] va;
    int          at;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int tests = 0;
  int fails = 0;

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(bit f, logic [19:0] vpn, logic [19:0] ppn,
                      bit berr, logic [31:0] a, int at);
    exp_t e;
    e.fault = f;
    e.vpn   = vpn;
    e.ppn   = ppn;
    e.berr  = berr;
    e.va    = a;
    e.at    = at;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  logic pf_prev = 1'b0;

  always @(negedge clock) begin
    if (we) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_we: got vpn %h ppn %h expected none",
                 wvp, wpp);
      end else begin
        me = sb.pop_front();
        check("we_kind", 32'(me.fault), 32'd0);
        check("we_vpn", 32'(wvp), 32'(me.vpn));
        check("we_ppn", 32'(wpp), 32'(me.ppn));
        check("we_cycle", cyc, me.at);
        check("we_stall", 32'(stall), 32'd1);
      end
    end
    if (pf && !pf_prev) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_fault: got va %h expected none", fva);
      end else begin
        me = sb.pop_front();
        check("pf_kind", 32'(me.fault), 32'd1);
        check("pf_berr", 32'(be), 32'(me.berr));
        check("pf_vaddr", fva, me.va);
        check("pf_cycle", cyc, me.at);
        check("pf_req", 32'(bus.mem_req_o), 32'd0);
        check("pf_stall", 32'(stall), 32'd0);
      end
    end
    pf_prev = pf;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1;
    int n;
    bit done;
    reset = 1'b1;
    miss  = 1'b0;
    va    = '0;
    priv  = 1'b0;
    ptbr  = '0;
    ack   = 1'b0;
    bus.mem_ready_i = 1'b0;
    bus.mem_data_i  = '0;

    repeat (2) @(negedge clock);
    check("rst_req", 32'(bus.mem_req_o), 32'd0);
    check("rst_addr", bus.mem_addr_o, 32'd0);
    check("rst_we", 32'(we), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_pf", 32'(pf), 32'd0);
    check("rst_be", 32'(be), 32'd0);
    check("rst_fva", fva, 32'd0);
    check("rst_w", {wvp, 12'd0} | 32'(wpp), 32'd0);
    step();
    reset = 1'b0;
    step();

    // basic refill, ready in the third WAIT cycle
    ptbr = 32'h0001_0000;
    va   = 32'h0040_3ABC;
    miss = 1'b1;
    @(negedge clock);
    check("refill_stall_miss", 32'(stall), 32'd1);
    step();
    c1 = cyc;
    push(0, 20'h00403, 20'h00077, 0, va, c1 + 4);
    @(negedge clock);
    check("refill_req", 32'(bus.mem_req_o), 32'd1);
    check("refill_addr", bus.mem_addr_o, 32'h0001_100C);
    check("refill_stall_req", 32'(stall), 32'd1);
    step();
    step();
    @(negedge clock);
    check("refill_addr_hold", bus.mem_addr_o, 32'h0001_100C);
    step();
    bus.mem_ready_i = 1'b1;
    bus.mem_data_i  = 32'h0007_7001;
    step();
    bus.mem_ready_i = 1'b0;
    bus.mem_data_i  = '0;
    @(negedge clock);
    check("refill_stall_fill", 32'(stall), 32'd1);
    step();
    @(negedge clock);
    check("refill_stall_settle", 32'(stall), 32'd1);
    step();
    miss = 1'b0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (bus.mem_req_o || stall) n++;
    end
    check("refill_single_walk", n, 0);

    // invalid PTE
    step();
    miss = 1'b1;
    step();
    c1 = cyc;
    push(1, 20'h0, 20'h0, 0, 32'h0040_3ABC, c1 + 4);
    step();
    step();
    step();
    bus.mem_ready_i = 1'b1;
    bus.mem_data_i  = 32'h0007_7000;
    step();
    bus.mem_ready_i = 1'b0;
    bus.mem_data_i  = '0;
    repeat (3) step();
    @(negedge clock);
    check("inv_pf_hold", 32'(pf), 32'd1);
    check("inv_fva_hold", fva, 32'h0040_3ABC);
    check("inv_stall", 32'(stall), 32'd0);
    miss = 1'b0;
    step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    @(negedge clock);
    check("inv_ack_pf", 32'(pf), 32'd0);
    check("inv_ack_be", 32'(be), 32'd0);

    // timeout
    step();
    ptbr = 32'h2000_0000;
    va   = 32'h1234_5678;
    miss = 1'b1;
    step();
    c1 = cyc;
    push(1, 20'h0, 20'h0, 1, 32'h1234_5678, c1 + 256);
    n = 0;
    done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clock);
      if (pf) done = 1;
      else if (bus.mem_req_o) n++;
    end
    check("to_reached", 32'(pf), 32'd1);
    check("to_req_cycles", n, 256);
    miss = 1'b0;
    step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    @(negedge clock);
    check("to_ack_pf", 32'(pf), 32'd0);
    check("to_ack_be", 32'(be), 32'd0);

    // privileged miss is never walked
    step();
    priv = 1'b1;
    va   = 32'h0AAA_A000;
    miss = 1'b1;
    @(negedge clock);
    check("priv_stall", 32'(stall), 32'd0);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (bus.mem_req_o || stall) n++;
    end
    check("priv_no_walk", n, 0);
    step();
    priv = 1'b0;
    miss = 1'b0;

    // address wrap, then reset during WAIT
    step();
    ptbr = 32'hFFFF_FFF0;
    va   = 32'h0000_5123;
    miss = 1'b1;
    step();
    @(negedge clock);
    check("wrap_addr", bus.mem_addr_o, 32'h0000_0004);
    step();
    step();
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_req", 32'(bus.mem_req_o), 32'd0);
    check("mid_rst_addr", bus.mem_addr_o, 32'd0);
    check("mid_rst_stall", 32'(stall), 32'd0);
    check("mid_rst_pf", 32'(pf), 32'd0);
    check("mid_rst_we", 32'(we), 32'd0);
    miss = 1'b0;
    bus.mem_ready_i = 1'b1;
    bus.mem_data_i  = 32'h0009_9001;
    step();
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (we || bus.mem_req_o || stall) n++;
    end
    check("late_ready_ignored", n, 0);
    bus.mem_ready_i = 1'b0;
    bus.mem_data_i  = '0;

    repeat (3) step();
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
